// File: rtl/id_stage_queue.sv
// id_stage_queue: decode stage fronted by an instruction FIFO.
//   Buffers fetched {pc, insn} pairs in a DEPTH-entry queue, decodes the queue head
//   (RV32I, optional RV32M, ecall/ebreak/mret, fence, CSR) and registers the result
//   into an output bundle handed to EX over a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               drop queue contents and the output bundle
//   i_in_valid/o_in_ready IF handshake carrying i_pc/i_insn
//   o_out_valid/i_out_ready EX handshake for the registered decode bundle
//   o_pc..o_illegal       registered decode bundle
//   o_count               queue occupancy (output register not counted)
module id_stage_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [31:0]                  i_pc,
  input  logic [31:0]                  i_insn,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [31:0]                  o_pc,
  output logic [31:0]                  o_insn,
  output logic [4:0]                   o_rd_addr,
  output logic [4:0]                   o_rs1_addr,
  output logic [4:0]                   o_rs2_addr,
  output logic                         o_rd_wr_en,
  output logic                         o_rs1_rd_sig,
  output logic                         o_rs2_rd_sig,
  output logic [3:0]                   o_alu_op,
  output logic [31:0]                  o_imm,
  output logic                         o_is_jal,
  output logic                         o_is_jalr,
  output logic                         o_is_br,
  output logic                         o_is_load,
  output logic                         o_is_store,
  output logic                         o_is_csr,
  output logic                         o_is_mul,
  output logic                         o_is_div,
  output logic                         o_mul_src1_signed,
  output logic                         o_mul_src2_signed,
  output logic                         o_mul_sel_high,
  output logic                         o_div_signed,
  output logic                         o_div_rem,
  output logic                         o_is_ecall,
  output logic                         o_is_ebreak,
  output logic                         o_is_mret,
  output logic                         o_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [6:0] OpLui = 7'b0110111, OpAuipc = 7'b0010111, OpJal = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111, OpBr = 7'b1100011, OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011, OpImm = 7'b0010011, OpReg = 7'b0110011;
  localparam logic [6:0] OpFence = 7'b0001111, OpSys = 7'b1110011;

  localparam logic [3:0] AluAdd = 4'd0, AluSub = 4'd1, AluSll = 4'd2, AluSlt = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4, AluXor = 4'd5, AluSrl = 4'd6, AluSra = 4'd7;
  localparam logic [3:0] AluOr = 4'd8, AluAnd = 4'd9, AluEq = 4'd10, AluNe = 4'd11;
  localparam logic [3:0] AluGe = 4'd12, AluGeu = 4'd13;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        rd_wr_en, rs1_rd, rs2_rd;
    logic [3:0]  alu_op;
    logic [31:0] imm;
    logic        is_jal, is_jalr, is_br, is_load, is_store, is_csr, is_mul, is_div;
    logic        mul_s1, mul_s2, mul_high, div_signed, div_rem;
    logic        is_ecall, is_ebreak, is_mret, illegal;
  } bundle_t;

  logic [31:0]     pc_mem   [DEPTH];
  logic [31:0]     insn_mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            out_valid_q;
  bundle_t         bundle_q, dec;
  logic            push, load, legal;

  // Queue control. Ready depends on occupancy only, so a full queue never
  // accepts even if the head is popped in the same cycle.
  assign o_in_ready = (count_q < CntW'(DEPTH));
  assign push       = i_in_valid & o_in_ready & ~i_flush;
  assign load       = (~out_valid_q | i_out_ready) & (count_q != '0) & ~i_flush;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (push && !load) begin
      count_d = count_q + CntW'(1);
    end else if (!push && load) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (i_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (load) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= i_pc;
      insn_mem[wr_ptr_q] <= i_insn;
    end
  end

  // Head decode.
  logic [31:0] insn;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [3:0]  alu_base;
  assign insn = insn_mem[rd_ptr_q];
  assign f3   = insn[14:12];
  assign f7   = insn[31:25];

  always_comb begin
    unique case (f3)
      3'b000:  alu_base = AluAdd;
      3'b001:  alu_base = AluSll;
      3'b010:  alu_base = AluSlt;
      3'b011:  alu_base = AluSltu;
      3'b100:  alu_base = AluXor;
      3'b101:  alu_base = insn[30] ? AluSra : AluSrl;
      3'b110:  alu_base = AluOr;
      default: alu_base = AluAnd;
    endcase
  end

  always_comb begin
    dec      = '0;
    legal    = 1'b0;
    dec.pc   = pc_mem[rd_ptr_q];
    dec.insn = insn;
    unique case (insn[6:0])
      OpLui, OpAuipc: begin
        legal        = 1'b1;
        dec.rd_wr_en = 1'b1;
        dec.imm      = {insn[31:12], 12'b0};
      end
      OpJal: begin
        legal        = 1'b1;
        dec.rd_wr_en = 1'b1;
        dec.is_jal   = 1'b1;
        dec.imm      = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      OpJalr: begin
        legal        = (f3 == 3'b000);
        dec.rd_wr_en = 1'b1;
        dec.rs1_rd   = 1'b1;
        dec.is_jalr  = 1'b1;
        dec.imm      = {{20{insn[31]}}, insn[31:20]};
      end
      OpBr: begin
        legal      = (f3 != 3'b010) && (f3 != 3'b011);
        dec.rs1_rd = 1'b1;
        dec.rs2_rd = 1'b1;
        dec.is_br  = 1'b1;
        dec.imm    = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        unique case (f3)
          3'b000:  dec.alu_op = AluEq;
          3'b001:  dec.alu_op = AluNe;
          3'b100:  dec.alu_op = AluSlt;
          3'b101:  dec.alu_op = AluGe;
          3'b110:  dec.alu_op = AluSltu;
          3'b111:  dec.alu_op = AluGeu;
          default: dec.alu_op = AluAdd;
        endcase
      end
      OpLoad: begin
        legal        = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        dec.rd_wr_en = 1'b1;
        dec.rs1_rd   = 1'b1;
        dec.is_load  = 1'b1;
        dec.imm      = {{20{insn[31]}}, insn[31:20]};
      end
      OpStore: begin
        legal        = f3 inside {3'b000, 3'b001, 3'b010};
        dec.rs1_rd   = 1'b1;
        dec.rs2_rd   = 1'b1;
        dec.is_store = 1'b1;
        dec.imm      = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      end
      OpImm: begin
        // Shift-immediates constrain funct7; srai is the only 0100000 form.
        legal = (f3 == 3'b001) ? (f7 == 7'b0) :
                (f3 == 3'b101) ? ((f7 == 7'b0) || (f7 == 7'b0100000)) : 1'b1;
        dec.rd_wr_en = 1'b1;
        dec.rs1_rd   = 1'b1;
        dec.alu_op   = alu_base;
        dec.imm      = {{20{insn[31]}}, insn[31:20]};
      end
      OpReg: begin
        dec.rd_wr_en = 1'b1;
        dec.rs1_rd   = 1'b1;
        dec.rs2_rd   = 1'b1;
        if (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          legal      = 1'b1;
          dec.alu_op = (f3 == 3'b000 && insn[30]) ? AluSub : alu_base;
        end else if (f7 == 7'b0000001 && ENABLE_M) begin
          legal = 1'b1;
          if (f3[2]) begin
            dec.is_div     = 1'b1;
            dec.div_signed = ~f3[0];
            dec.div_rem    = f3[1];
          end else begin
            dec.is_mul   = 1'b1;
            dec.mul_s1   = (f3 != 3'b011);
            dec.mul_s2   = (f3 == 3'b000) || (f3 == 3'b001);
            dec.mul_high = (f3 != 3'b000);
          end
        end
      end
      OpFence: legal = (f3 == 3'b000);
      OpSys: begin
        if (insn == 32'h0000_0073) begin
          legal        = 1'b1;
          dec.is_ecall = 1'b1;
        end else if (insn == 32'h0010_0073) begin
          legal         = 1'b1;
          dec.is_ebreak = 1'b1;
        end else if (insn == 32'h3020_0073) begin
          legal       = 1'b1;
          dec.is_mret = 1'b1;
        end else if (f3[1:0] != 2'b00) begin
          legal        = 1'b1;
          dec.is_csr   = 1'b1;
          dec.rd_wr_en = 1'b1;
          dec.rs1_rd   = ~f3[2];
          dec.imm      = f3[2] ? {27'b0, insn[19:15]} : 32'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.pc      = pc_mem[rd_ptr_q];
      dec.insn    = insn;
      dec.illegal = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else if (i_flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      bundle_q    <= dec;
    end else if (i_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign o_out_valid       = out_valid_q;
  assign o_count           = count_q;
  assign o_pc              = bundle_q.pc;
  assign o_insn            = bundle_q.insn;
  assign o_rd_addr         = bundle_q.insn[11:7];
  assign o_rs1_addr        = bundle_q.insn[19:15];
  assign o_rs2_addr        = bundle_q.insn[24:20];
  assign o_rd_wr_en        = bundle_q.rd_wr_en;
  assign o_rs1_rd_sig      = bundle_q.rs1_rd;
  assign o_rs2_rd_sig      = bundle_q.rs2_rd;
  assign o_alu_op          = bundle_q.alu_op;
  assign o_imm             = bundle_q.imm;
  assign o_is_jal          = bundle_q.is_jal;
  assign o_is_jalr         = bundle_q.is_jalr;
  assign o_is_br           = bundle_q.is_br;
  assign o_is_load         = bundle_q.is_load;
  assign o_is_store        = bundle_q.is_store;
  assign o_is_csr          = bundle_q.is_csr;
  assign o_is_mul          = bundle_q.is_mul;
  assign o_is_div          = bundle_q.is_div;
  assign o_mul_src1_signed = bundle_q.mul_s1;
  assign o_mul_src2_signed = bundle_q.mul_s2;
  assign o_mul_sel_high    = bundle_q.mul_high;
  assign o_div_signed      = bundle_q.div_signed;
  assign o_div_rem         = bundle_q.div_rem;
  assign o_is_ecall        = bundle_q.is_ecall;
  assign o_is_ebreak       = bundle_q.is_ebreak;
  assign o_is_mret         = bundle_q.is_mret;
  assign o_illegal         = bundle_q.illegal;

endmodule

// File: tb/tb_id_stage_queue.sv
// Bench for id_stage_queue: scoreboard of expected decode bundles, filled on each
// accepted enqueue and drained as EX handshakes bundles out. A second instance with
// ENABLE_M=0 shares all inputs and is checked against the same scoreboard.
module tb_id_stage_queue;

  localparam logic [19:0] FRd = 20'h80000, FRs1 = 20'h40000, FRs2 = 20'h20000;
  localparam logic [19:0] FJal = 20'h10000, FJalr = 20'h08000, FBr = 20'h04000;
  localparam logic [19:0] FLd = 20'h02000, FSt = 20'h01000, FCsr = 20'h00800;
  localparam logic [19:0] FMul = 20'h00400, FDiv = 20'h00200, FMs1 = 20'h00100;
  localparam logic [19:0] FMs2 = 20'h00080, FMhi = 20'h00040, FDsg = 20'h00020;
  localparam logic [19:0] FDrem = 20'h00010, FEcall = 20'h00008, FEbrk = 20'h00004;
  localparam logic [19:0] FMret = 20'h00002, FIll = 20'h00001;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [19:0] fl;
    logic        nm_ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] pc, insn;

  logic        in_ready, out_valid, rd_wr_en, rs1_rd, rs2_rd;
  logic [31:0] o_pc, o_insn, o_imm;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [3:0]  alu_op;
  logic        is_jal, is_jalr, is_br, is_load, is_store, is_csr, is_mul, is_div;
  logic        ms1, ms2, mhi, dsg, drem, ecall, ebreak, mret, illegal;
  logic [2:0]  count;

  logic        nm_in_ready, nm_out_valid, nm_rd_wr_en, nm_rs1_rd, nm_rs2_rd;
  logic [31:0] nm_pc, nm_insn, nm_imm;
  logic [4:0]  nm_rd_a, nm_rs1_a, nm_rs2_a;
  logic [3:0]  nm_alu_op;
  logic        nm_jal, nm_jalr, nm_br, nm_load, nm_store, nm_csr, nm_mul, nm_div;
  logic        nm_ms1, nm_ms2, nm_mhi, nm_dsg, nm_drem, nm_ecall, nm_ebreak, nm_mret, nm_ill;
  logic [2:0]  nm_count;

  logic [19:0] obs_fl, nm_fl;
  assign obs_fl = {rd_wr_en, rs1_rd, rs2_rd, is_jal, is_jalr, is_br, is_load, is_store, is_csr,
                   is_mul, is_div, ms1, ms2, mhi, dsg, drem, ecall, ebreak, mret, illegal};
  assign nm_fl  = {nm_rd_wr_en, nm_rs1_rd, nm_rs2_rd, nm_jal, nm_jalr, nm_br, nm_load,
                   nm_store, nm_csr, nm_mul, nm_div, nm_ms1, nm_ms2, nm_mhi, nm_dsg, nm_drem,
                   nm_ecall, nm_ebreak, nm_mret, nm_ill};

  id_stage_queue #(.DEPTH(4), .ENABLE_M(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_pc(pc), .i_insn(insn), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_pc(o_pc), .o_insn(o_insn), .o_rd_addr(rd_a),
    .o_rs1_addr(rs1_a), .o_rs2_addr(rs2_a), .o_rd_wr_en(rd_wr_en), .o_rs1_rd_sig(rs1_rd),
    .o_rs2_rd_sig(rs2_rd), .o_alu_op(alu_op), .o_imm(o_imm), .o_is_jal(is_jal),
    .o_is_jalr(is_jalr), .o_is_br(is_br), .o_is_load(is_load), .o_is_store(is_store),
    .o_is_csr(is_csr), .o_is_mul(is_mul), .o_is_div(is_div), .o_mul_src1_signed(ms1),
    .o_mul_src2_signed(ms2), .o_mul_sel_high(mhi), .o_div_signed(dsg), .o_div_rem(drem),
    .o_is_ecall(ecall), .o_is_ebreak(ebreak), .o_is_mret(mret), .o_illegal(illegal),
    .o_count(count)
  );

  id_stage_queue #(.DEPTH(4), .ENABLE_M(1'b0)) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(nm_in_ready), .i_pc(pc), .i_insn(insn), .o_out_valid(nm_out_valid),
    .i_out_ready(out_ready), .o_pc(nm_pc), .o_insn(nm_insn), .o_rd_addr(nm_rd_a),
    .o_rs1_addr(nm_rs1_a), .o_rs2_addr(nm_rs2_a), .o_rd_wr_en(nm_rd_wr_en),
    .o_rs1_rd_sig(nm_rs1_rd), .o_rs2_rd_sig(nm_rs2_rd), .o_alu_op(nm_alu_op), .o_imm(nm_imm),
    .o_is_jal(nm_jal), .o_is_jalr(nm_jalr), .o_is_br(nm_br), .o_is_load(nm_load),
    .o_is_store(nm_store), .o_is_csr(nm_csr), .o_is_mul(nm_mul), .o_is_div(nm_div),
    .o_mul_src1_signed(nm_ms1), .o_mul_src2_signed(nm_ms2), .o_mul_sel_high(nm_mhi),
    .o_div_signed(nm_dsg), .o_div_rem(nm_drem), .o_is_ecall(nm_ecall),
    .o_is_ebreak(nm_ebreak), .o_is_mret(nm_mret), .o_illegal(nm_ill), .o_count(nm_count)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  int   n_pops = 0;
  int   pc_n = 0;
  exp_t tbl[17];
  exp_t sb[$];
  exp_t cur_exp;
  exp_t mon_e;
  logic rand_rdy = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] i, input logic [3:0] a, input logic [31:0] im,
                              input logic [19:0] f, input logic nm);
    exp_t e;
    e.pc = '0; e.insn = i; e.alu = a; e.imm = im; e.fl = f; e.nm_ill = nm;
    return e;
  endfunction

  // Handshakes complete at the next rising edge; decide them at the falling edge.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("pc", o_pc, mon_e.pc);
          check_eq("insn", o_insn, mon_e.insn);
          check_eq("alu_op", alu_op, mon_e.alu);
          check_eq("imm", o_imm, mon_e.imm);
          check_eq("flags", obs_fl, mon_e.fl);
          check_eq("regs", {rd_a, rs1_a, rs2_a},
                   {mon_e.insn[11:7], mon_e.insn[19:15], mon_e.insn[24:20]});
          check_eq("nm_valid", nm_out_valid, 1);
          check_eq("nm_flags", nm_fl, mon_e.nm_ill ? FIll : mon_e.fl);
        end
      end else if (out_valid) begin
        if (sb.size() != 0) check_eq("stall_insn", o_insn, sb[0].insn);
        else check_eq("stall_empty", out_valid, 0);
      end
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    in_valid = 1'b1;
    pc       = 32'h1000 + 32'(4 * pc_n);
    pc_n++;
    insn     = tbl[idx].insn;
    cur_exp  = tbl[idx];
    cur_exp.pc = pc;
  endtask

  task automatic attempt(input int idx);
    drive(idx);
    step();
  endtask

  task automatic send(input int idx);
    int a0;
    a0 = acc_cnt;
    drive(idx);
    for (int k = 0; k < 50; k++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      step();
      if (acc_cnt != a0) break;
    end
    check_eq("send_accepted", 64'(acc_cnt - a0), 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0 && !out_valid) break;
      step();
    end
    check_eq("drain", 64'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(32'h00500093, 4'd0,  32'd5,        FRd | FRs1, 1'b0);
    tbl[1]  = mk(32'hFE000EE3, 4'd10, 32'hFFFFFFFC, FRs1 | FRs2 | FBr, 1'b0);
    tbl[2]  = mk(32'h40208133, 4'd1,  32'd0,        FRd | FRs1 | FRs2, 1'b0);
    tbl[3]  = mk(32'h0220C1B3, 4'd0,  32'd0,        FRd | FRs1 | FRs2 | FDiv | FDsg, 1'b1);
    tbl[4]  = mk(32'h00000000, 4'd0,  32'd0,        FIll, 1'b1);
    tbl[5]  = mk(32'h30200073, 4'd0,  32'd0,        FMret, 1'b0);
    tbl[6]  = mk(32'h0000000F, 4'd0,  32'd0,        20'h0, 1'b0);
    tbl[7]  = mk(32'h027322B3, 4'd0,  32'd0,        FRd | FRs1 | FRs2 | FMul | FMs1 | FMhi, 1'b1);
    tbl[8]  = mk(32'hFF812203, 4'd0,  32'hFFFFFFF8, FRd | FRs1 | FLd, 1'b0);
    tbl[9]  = mk(32'h0050A623, 4'd0,  32'd12,       FRs1 | FRs2 | FSt, 1'b0);
    tbl[10] = mk(32'h3008D1F3, 4'd0,  32'd17,       FRd | FCsr, 1'b0);
    tbl[11] = mk(32'h3053A373, 4'd0,  32'd0,        FRd | FRs1 | FCsr, 1'b0);
    tbl[12] = mk(32'h010000EF, 4'd0,  32'd16,       FRd | FJal, 1'b0);
    tbl[13] = mk(32'h4031D113, 4'd7,  32'h403,      FRd | FRs1, 1'b0);
    tbl[14] = mk(32'h123452B7, 4'd0,  32'h12345000, FRd, 1'b0);
    tbl[15] = mk(32'h00100073, 4'd0,  32'd0,        FEbrk, 1'b0);
    tbl[16] = mk(32'h00000073, 4'd0,  32'd0,        FEcall, 1'b0);

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc = '0; insn = '0;
    cur_exp = tbl[0];
    #2 rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_bundle", {o_pc, o_insn}, 64'h0);
    check_eq("rst_flags", {alu_op, o_imm, obs_fl}, 56'h0);
    rst_n = 1'b1;
    step();

    // Latency: accepted at edge t, valid after edge t+1.
    out_ready = 1'b1;
    drive(0);
    step();
    in_valid = 1'b0;
    check_eq("lat_edge_t", out_valid, 0);
    step();
    check_eq("lat_edge_t1", out_valid, 1);
    check_eq("lat_imm", o_imm, 5);
    drain();

    // Branch, sub, div (and div as illegal on the ENABLE_M=0 instance).
    for (int i = 1; i <= 3; i++) send(i);
    drain();

    // Backpressure: 8 pushes with EX stalled, exactly 5 land.
    begin
      int a0, p0;
      out_ready = 1'b0;
      a0 = acc_cnt;
      for (int i = 0; i < 8; i++) attempt(4 + i);
      in_valid = 1'b0;
      check_eq("bp_accepted", 64'(acc_cnt - a0), 5);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_count", count, 4);
      check_eq("bp_valid", out_valid, 1);
      repeat (3) step();
      out_ready = 1'b1;
      p0 = n_pops;
      repeat (5) step();
      check_eq("bp_pops", 64'(n_pops - p0), 5);
      check_eq("bp_count_end", count, 0);
      check_eq("bp_valid_end", out_valid, 0);
    end

    // Flush with count=3 and a same-cycle push.
    begin
      int p0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) attempt(12 + i);
      in_valid = 1'b0;
      check_eq("fl_count_pre", count, 3);
      flush = 1'b1;
      drive(0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      check_eq("fl_count", count, 0);
      check_eq("fl_valid", out_valid, 0);
      check_eq("fl_in_ready", in_ready, 1);
      out_ready = 1'b1;
      p0 = n_pops;
      repeat (4) step();
      check_eq("fl_no_output", 64'(n_pops - p0), 0);
    end

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) attempt(6 + i);
    in_valid = 1'b0;
    step();
    check_eq("ar_valid_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_valid", out_valid, 0);
    check_eq("ar_count", count, 0);
    check_eq("ar_in_ready", in_ready, 1);
    check_eq("ar_bundle", {o_pc, o_insn}, 64'h0);
    check_eq("ar_flags", {alu_op, o_imm, obs_fl}, 56'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Whole table with random EX backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 17; i++) send(i);
    rand_rdy = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
